// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: FWFT FIFO of {pc, instr, adel} with redirect flush.
// Optional same-cycle empty bypass when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AW        = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_instr,
  output logic          in_ready,
  output logic          out_valid,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_instr,
  output logic          out_adel,
  input  logic          out_ready,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic          adel_mem  [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          push, pop, wr_en;

  assign count    = cnt;
  assign full     = (cnt == FULL_CNT);
  assign empty    = (cnt == '0);
  assign in_ready = !full;
  assign pop      = !empty && out_ready;
  assign wr_en    = push && !flush && !reset;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;
  // An empty queue forwards the fetch pair directly; it is only stored if decode stalls.
  assign bypass    = empty && in_valid && !flush && !reset;
  assign out_valid = !empty || bypass;
  assign push      = in_valid && in_ready && !(bypass && out_ready);
`else
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
`endif

  always_comb begin
    out_pc    = '0;
    out_instr = NOP_INSTR;
    out_adel  = 1'b0;
    if (!empty) begin
      out_pc    = pc_mem[rp];
      out_instr = instr_mem[rp];
      out_adel  = adel_mem[rp];
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    else if (bypass) begin
      out_pc    = in_pc;
      out_instr = in_instr;
      out_adel  = |in_pc[1:0];
    end
`endif
  end

  // Payload storage is never cleared; only pointers and occupancy are reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wp]    <= in_pc;
      instr_mem[wp] <= in_instr;
      adel_mem[wp]  <= |in_pc[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + PTR_ONE;
      if (pop)  rp <= rp + PTR_ONE;
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a scoreboard queue models the FIFO and every cycle
// the DUT head, occupancy and flags are checked against it.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          reset = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0]   in_pc = '0, in_instr = '0;
  logic          in_ready, out_valid, out_adel, full, empty;
  logic [31:0]   out_pc, out_instr;
  logic [AW:0]   count;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [64:0] sb [$];   // {adel, pc, instr}

  fetch_queue #(.DEPTH(DEPTH), .AW(AW), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_adel(out_adel),
    .out_ready(out_ready), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle at the negedge, check just after, then advance the model at the posedge.
  task automatic step(input logic rst, input logic fl, input logic iv, input logic [31:0] pc,
                      input logic [31:0] ins, input logic ordy, input logic do_chk);
    logic        e_valid, e_adel, byp, do_pop, do_push;
    logic [31:0] e_pc, e_ins;
    int unsigned sz;
    reset = rst; flush = fl; in_valid = iv; in_pc = pc; in_instr = ins; out_ready = ordy;
    #1;
    sz = sb.size();
    byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (sz == 0) && iv && !fl && !rst;
`endif
    if (sz != 0) begin
      e_valid = 1'b1; e_adel = sb[0][64]; e_pc = sb[0][63:32]; e_ins = sb[0][31:0];
    end else if (byp) begin
      e_valid = 1'b1; e_adel = (pc[1:0] != 2'b00); e_pc = pc; e_ins = ins;
    end else begin
      e_valid = 1'b0; e_adel = 1'b0; e_pc = 32'h0; e_ins = NOP;
    end
    if (do_chk) begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, e_valid});
      chk("out_pc",    out_pc,    e_pc);
      chk("out_instr", out_instr, e_ins);
      chk("out_adel",  {31'b0, out_adel}, {31'b0, e_adel});
      chk("count",     {29'b0, count}, sz);
      chk("full",      {31'b0, full},     {31'b0, sz == DEPTH});
      chk("empty",     {31'b0, empty},    {31'b0, sz == 0});
      chk("in_ready",  {31'b0, in_ready}, {31'b0, sz != DEPTH});
    end
    if (rst || fl) begin
      sb.delete();
    end else if (!(byp && ordy)) begin
      do_pop  = (sz != 0) && ordy;
      do_push = iv && (sz < DEPTH);
      if (do_pop)  void'(sb.pop_front());
      if (do_push) sb.push_back({(pc[1:0] != 2'b00), pc, ins});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return 32'h2400_0000 ^ pc;
  endfunction

  initial begin
    @(negedge clk);
    // reset held two cycles with fetch still presenting data
    step(1, 0, 1, 32'h1000, ins_of(32'h1000), 0, 0);
    step(1, 0, 1, 32'h1004, ins_of(32'h1004), 0, 1);
    step(0, 0, 0, 32'h0, 32'h0, 0, 1);

    // ordered fill to full, refused 5th push, then drain in order
    for (int i = 0; i < 4; i++)
      step(0, 0, 1, 32'h3000 + 32'(4*i), ins_of(32'h3000 + 32'(4*i)), 0, 1);
    step(0, 0, 1, 32'h3010, ins_of(32'h3010), 0, 1);
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 32'h0, 32'h0, 1, 1);
    step(0, 0, 0, 32'h0, 32'h0, 0, 1);

    // steady two-entry push+pop across pointer wrap
    for (int i = 0; i < 2; i++)
      step(0, 0, 1, 32'h3100 + 32'(4*i), ins_of(32'h3100 + 32'(4*i)), 0, 1);
    for (int i = 2; i < 12; i++)
      step(0, 0, 1, 32'h3100 + 32'(4*i), ins_of(32'h3100 + 32'(4*i)), 1, 1);
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 32'h0, 32'h0, 1, 1);

    // flush with concurrent push and pop, then restart
    for (int i = 0; i < 3; i++)
      step(0, 0, 1, 32'h3200 + 32'(4*i), ins_of(32'h3200 + 32'(4*i)), 0, 1);
    step(0, 1, 1, 32'h4000, ins_of(32'h4000), 1, 1);
    step(0, 0, 1, 32'h4000, ins_of(32'h4000), 0, 1);
    step(0, 0, 0, 32'h0, 32'h0, 1, 1);
    step(0, 0, 0, 32'h0, 32'h0, 0, 1);

    // misaligned PC tag
    step(0, 0, 1, 32'h3002, 32'h8C01_0000, 0, 1);
    step(0, 0, 1, 32'h3008, ins_of(32'h3008), 0, 1);
    step(0, 0, 0, 32'h0, 32'h0, 1, 1);
    step(0, 0, 0, 32'h0, 32'h0, 1, 1);
    step(0, 0, 0, 32'h0, 32'h0, 0, 1);

    // empty queue with push and pop together (bypass path in that build)
    step(0, 0, 1, 32'h3000, ins_of(32'h3000), 1, 1);
    step(0, 0, 0, 32'h0, 32'h0, 1, 1);
    step(0, 0, 0, 32'h0, 32'h0, 0, 1);

    // mid-operation reset drops entries
    step(0, 0, 1, 32'h5000, ins_of(32'h5000), 0, 1);
    step(0, 0, 1, 32'h5004, ins_of(32'h5004), 0, 1);
    step(1, 0, 1, 32'h5008, ins_of(32'h5008), 1, 1);
    step(0, 0, 0, 32'h0, 32'h0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction queue between the fetch stage (PC register plus instruction memory) and the decode stage of the 5-stage MIPS pipeline.
- Buffers {PC, instruction} pairs so fetch can keep running while decode stalls.
- Drops all buffered work on a redirect (branch, jump or reset).
- Tags misaligned-PC entries for the decode and exception logic.

Parameters:
DEPTH, 4, number of entries; must be a power of 2, minimum 2
AW, 2, pointer width, log2(DEPTH)
NOP_INSTR, 32'h00000000, instruction word driven on out_instr when the queue is empty (sll $0,$0,0)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous discard of all entries (redirect)
in_valid  input  1  fetch stage presents a valid pair
in_pc  input  32  PC of the fetched instruction
in_instr  input  32  fetched instruction word
in_ready  output  1  queue accepts a push this cycle
out_valid  output  1  head entry valid
out_pc  output  32  PC of the head entry
out_instr  output  32  instruction word of the head entry
out_adel  output  1  head entry PC not word-aligned (in_pc[1:0] != 0 at push)
out_ready  input  1  decode consumes the head this cycle
count  output  AW+1  number of valid entries, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
- Interface: reset is synchronous, active-high (reset); clock is clk.
- Storage:
  - DEPTH entries of {pc[31:0], instr[31:0], adel}.
  - Write pointer wp, read pointer rp, each AW bits, wrapping modulo DEPTH.
  - Occupancy counter cnt, AW+1 bits.
- Push: fires when in_valid && in_ready. Writes entry[wp], then wp <= wp+1.
- Pop: fires when out_valid && out_ready. Then rp <= rp+1.
- in_ready = !full.
  - A full queue refuses a push even if a pop fires in the same cycle; there is no full-pass-through.
- out_valid = !empty.
- Head output is first-word-fall-through: out_pc, out_instr and out_adel are driven combinationally from entry[rp].
- When empty: out_pc = 32'h0, out_instr = NOP_INSTR, out_adel = 0.
- Latency: an entry pushed in cycle N appears on out_* in cycle N+1 (base build).
- cnt update:
  - push only: +1
  - pop only: -1
  - push and pop in the same cycle: unchanged, and both pointers advance.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no stall or bubble.
- flush:
  - Next edge sets wp = rp = 0 and cnt = 0.
  - A push or pop in the same cycle is discarded; flush has priority.
  - out_valid = 0 in cycle N+1.
  - A push in cycle N+1 is accepted normally.
- reset: same effect as flush and takes priority over everything. Mid-operation reset loses all entries.
- Entry payload is not cleared on flush or reset; only the pointers and counter are.
- Reset values:
  - in_ready = 1, out_valid = 0, count = 0, full = 0, empty = 1.
  - out_pc = 0, out_instr = NOP_INSTR, out_adel = 0.
- Entries never reorder. No entry is duplicated or dropped except by flush or reset.
- Fault:
  - in_valid while full leaves the state unchanged; the fetch stage must hold its PC.
  - A pop while empty is ignored.

Optional Feature:
- Macro FETCH_QUEUE_BYPASS_EN.
- When defined:
  - If empty && in_valid && out_ready && !flush, the input pair drives out_* combinationally in the same cycle.
  - out_valid = 1 in that cycle.
  - The pair is consumed without being written; pointers and cnt stay unchanged.
  - If empty && in_valid && !out_ready, the pair is stored and out_* shows it in that cycle through the bypass path.
- When undefined: no combinational path from in_* to out_*; latency is exactly 1 cycle as specified above.

Test Plan:
- Reset: assert reset for 2 cycles with in_valid = 1. Required: count = 0, empty = 1, in_ready = 1, out_instr = 32'h0 after release.
- Ordered fill: push PCs 0x3000, 0x3004, 0x3008, 0x300C with out_ready = 0.
  - Required: full = 1 and in_ready = 0 after the 4th push.
  - Required: a 5th push at 0x3010 is refused and count stays 4.
  - Then raise out_ready. Required: pops return 0x3000..0x300C in order, with instr matching.
- Simultaneous push/pop with 2 entries: run 10 cycles of continuous push+pop. Required: count stays 2, pointers wrap past DEPTH, output order is preserved.
- Flush: queue holds 3 entries; in one cycle assert flush + in_valid (pc 0x4000) + out_ready.
  - Required next cycle: count = 0, out_valid = 0.
  - Required: a push of 0x4000 in the following cycle appears on out_pc one cycle later.
- Misaligned PC: push pc 0x3002, instr 0x8C010000. Required: out_adel = 1 with out_pc = 0x3002; the next aligned entry has out_adel = 0.
- Bypass build: with the queue empty, drive in_valid = 1, pc 0x3000, and out_ready = 1.
  - Required: out_valid = 1 and out_pc = 0x3000 in the same cycle, with count staying 0.
  - Base build: out_valid stays 0 in that cycle.
